cache_arbiter: RTL and testbench

- Shares the single physical-memory line port between the I-cache miss path and the D-cache miss/writeback path of the 5-stage pipeline.
- Sits between the two L1 caches and the cacheline adaptor/L2.
- Grants one requester at a time and latches its address and write data for the whole transaction.
- Routes the memory response back only to the granted cache.

---
 rtl/cache_arb_pkg.sv | 28 ++
 rtl/arb_grant_sel.sv | 35 +++
 rtl/cache_arbiter.sv | 123 ++++++++++++
 tb/tb_cache_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
// cache_arb_pkg: shared types for the L1 miss-path arbiter.
//   DEF_LINE_WIDTH / DEF_ADDR_WIDTH : default line and address widths
//   arb_state_t                     : arbiter FSM states
//   arb_src_t                       : requester identity (I-cache or D-cache)
//   line_t                          : one cache line at the default width
package cache_arb_pkg;

    localparam int DEF_LINE_WIDTH = 256;
    localparam int DEF_ADDR_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } arb_state_t;

    typedef enum logic {
        SRC_I,
        SRC_D
    } arb_src_t;

    typedef logic [DEF_LINE_WIDTH-1:0] line_t;

    function automatic arb_state_t serve_state(input arb_src_t src);
        return (src == SRC_D) ? SERVE_D : SERVE_I;
    endfunction

endpackage

// File: rtl/arb_grant_sel.sv
// arb_grant_sel: combinational request-to-grant selection.
// Optional feature macro: CACHE_ARB_RR_EN (round-robin on ties).
//   i_req      : I-cache is requesting
//   d_req      : D-cache is requesting (read or writeback)
//   last_grant : side granted most recently (only with CACHE_ARB_RR_EN)
//   grant_vld  : some requester is present
//   grant_src  : side to grant when grant_vld is set
module arb_grant_sel
    import cache_arb_pkg::*;
(
    input  logic     i_req,
    input  logic     d_req,
`ifdef CACHE_ARB_RR_EN
    input  arb_src_t last_grant,
`endif
    output logic     grant_vld,
    output arb_src_t grant_src
);

    always_comb begin
        grant_vld = i_req | d_req;
        grant_src = SRC_I;
        if (i_req && d_req) begin
`ifdef CACHE_ARB_RR_EN
            // tie goes to whichever side did not win last time
            grant_src = (last_grant == SRC_I) ? SRC_D : SRC_I;
`else
            grant_src = SRC_D;
`endif
        end else if (d_req) begin
            grant_src = SRC_D;
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one physical-memory line port between the I-cache
// miss path and the D-cache miss/writeback path.
// Optional feature macro: CACHE_ARB_RR_EN (round-robin instead of D-over-I).
//   clk, rst                          : clock, synchronous active-low reset
//   i_read, i_addr, i_rdata, i_resp   : I-cache fill port
//   d_read, d_write, d_addr, d_wdata,
//   d_rdata, d_resp                   : D-cache fill/writeback port
//   pmem_read, pmem_write, pmem_addr,
//   pmem_wdata, pmem_rdata, pmem_resp : memory-side line port
//
// state   | meaning
// IDLE    | no transaction; arbitrate incoming requests
// SERVE_I | I-cache fill in flight, waiting for pmem_resp
// SERVE_D | D-cache fill or writeback in flight, waiting for pmem_resp
module cache_arbiter
    import cache_arb_pkg::*;
#(
    parameter int LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_addr,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    arb_state_t            state_q, state_d;
    logic                  op_write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic                  grant_vld;
    arb_src_t              grant_src;
    logic                  take_grant;
    logic                  busy;

`ifdef CACHE_ARB_RR_EN
    arb_src_t last_grant_q;
`endif

    arb_grant_sel u_grant_sel (
        .i_req      (i_read),
        .d_req      (d_read | d_write),
`ifdef CACHE_ARB_RR_EN
        .last_grant (last_grant_q),
`endif
        .grant_vld  (grant_vld),
        .grant_src  (grant_src)
    );

    assign take_grant = (state_q == IDLE) && grant_vld;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:             if (grant_vld) state_d = serve_state(grant_src);
            SERVE_I, SERVE_D: if (pmem_resp) state_d = IDLE;
            default:          state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            op_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q <= state_d;
            if (take_grant) begin
                if (grant_src == SRC_D) begin
                    addr_q     <= d_addr;
                    wdata_q    <= d_wdata;
                    // read+write together is illegal; the write wins
                    op_write_q <= d_write;
                end else begin
                    addr_q     <= i_addr;
                    op_write_q <= 1'b0;
                end
            end
        end
    end

`ifdef CACHE_ARB_RR_EN
    // reset to I so that D wins the first tie
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant_q <= SRC_I;
        end else if (take_grant) begin
            last_grant_q <= grant_src;
        end
    end
`endif

    // Outputs are gated by rst so a mid-transaction reset drops the
    // strobes and suppresses any resp in the same cycle.
    assign busy       = rst && (state_q != IDLE);
    assign pmem_read  = busy && !op_write_q;
    assign pmem_write = busy && op_write_q;
    assign pmem_addr  = rst ? addr_q  : '0;
    assign pmem_wdata = rst ? wdata_q : '0;
    assign i_resp     = rst && (state_q == SERVE_I) && pmem_resp;
    assign d_resp     = rst && (state_q == SERVE_D) && pmem_resp;
    assign i_rdata    = pmem_rdata;
    assign d_rdata    = pmem_rdata;

    a_no_rw_both : assert property (@(posedge clk) disable iff (!rst)
                                    !(d_read && d_write));

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_read;
    logic [31:0]  i_addr;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_addr;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_addr;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit           is_d;
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
    } txn_t;

    txn_t sb[$];

    always #5 clk = ~clk;

    cache_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .i_read     (i_read),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_resp     (i_resp),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_resp     (d_resp),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write),
        .pmem_addr  (pmem_addr),
        .pmem_wdata (pmem_wdata),
        .pmem_rdata (pmem_rdata),
        .pmem_resp  (pmem_resp)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic txn_t mk(input bit is_d, input bit wr, input logic [31:0] a,
                                input logic [255:0] w);
        txn_t t;
        t.is_d  = is_d;
        t.wr    = wr;
        t.addr  = a;
        t.wdata = w;
        return t;
    endfunction

    // Acts as the memory for one transaction: pops the expected grant from the
    // scoreboard, waits for the strobe, responds after 'delay' cycles.
    task automatic mem_txn(input string tag, input int delay, input logic [255:0] rd,
                           input int exp_wait);
        txn_t exp;
        int   n;
        n = 0;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1'b1, 1'b0);
            return;
        end
        exp = sb.pop_front();
        while (!(pmem_read || pmem_write) && n < 20) begin
            step();
            n++;
        end
        check({tag, "_timeout"}, (n < 20), 1'b1);
        if (exp_wait >= 0) check({tag, "_latency"}, n, exp_wait);
        check({tag, "_pmem_read"},  pmem_read,  !exp.wr);
        check({tag, "_pmem_write"}, pmem_write, exp.wr);
        check({tag, "_pmem_addr"},  pmem_addr,  exp.addr);
        if (exp.wr) check({tag, "_pmem_wdata"}, pmem_wdata, exp.wdata);
        for (int k = 0; k < delay; k++) begin
            step();
            check({tag, "_hold_strobe"}, {pmem_read, pmem_write}, {!exp.wr, exp.wr});
            check({tag, "_hold_addr"}, pmem_addr, exp.addr);
            check({tag, "_early_resp"}, {i_resp, d_resp}, 2'b00);
        end
        pmem_rdata = rd;
        pmem_resp  = 1'b1;
        #1;
        check({tag, "_i_resp"}, i_resp, !exp.is_d);
        check({tag, "_d_resp"}, d_resp, exp.is_d);
        if (exp.is_d) check({tag, "_d_rdata"}, d_rdata, rd);
        else          check({tag, "_i_rdata"}, i_rdata, rd);
        step();
        pmem_resp = 1'b0;
        #1;
        check({tag, "_post_strobe"}, {pmem_read, pmem_write}, 2'b00);
        check({tag, "_post_resp"}, {i_resp, d_resp}, 2'b00);
    endtask

    initial begin
        logic [255:0] pat_a5;
        logic [255:0] pat_db;
        bit           rr_d [4];

        pat_a5 = {32{8'hA5}};
        pat_db = {8{32'hDEADBEEF}};
`ifdef CACHE_ARB_RR_EN
        rr_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        rr_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

        rst = 1'b0;
        i_read = 1'b0; i_addr = '0;
        d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;

        // reset / idle
        step();
        step();
        check("rst_strobes", {pmem_read, pmem_write}, 2'b00);
        check("rst_resps", {i_resp, d_resp}, 2'b00);
        check("rst_addr", pmem_addr, 32'h0);
        check("rst_wdata", pmem_wdata, 256'h0);
        rst = 1'b1;
        step();
        pmem_resp = 1'b1;
        #1;
        check("idle_resp_ignored", {i_resp, d_resp}, 2'b00);
        step();
        pmem_resp = 1'b0;
        #1;
        check("idle_strobes", {pmem_read, pmem_write}, 2'b00);

        // single I fill
        i_read = 1'b1;
        i_addr = 32'h0000_1040;
        sb.push_back(mk(1'b0, 1'b0, 32'h0000_1040, '0));
        #1;
        check("ifill_no_same_cycle", pmem_read, 1'b0);
        mem_txn("ifill", 5, pat_a5, 1);
        i_read = 1'b0;
        step();

        // D writeback, requester inputs cleared right after the grant
        d_write = 1'b1;
        d_addr  = 32'h8000_0020;
        d_wdata = pat_db;
        sb.push_back(mk(1'b1, 1'b1, 32'h8000_0020, pat_db));
        step();
        d_write = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        mem_txn("dwb", 3, {8{32'h1234_5678}}, 0);
        step();

        // simultaneous: D first, then I after one IDLE bubble
        i_read = 1'b1; i_addr = 32'h0000_2000;
        d_read = 1'b1; d_addr = 32'h0000_3000;
        sb.push_back(mk(1'b1, 1'b0, 32'h0000_3000, '0));
        sb.push_back(mk(1'b0, 1'b0, 32'h0000_2000, '0));
        mem_txn("sim_d", 2, {32{8'h3C}}, 1);
        d_read = 1'b0;
        mem_txn("sim_i", 1, {32{8'hC3}}, 1);
        i_read = 1'b0;
        step();

        // both requesting continuously for four transactions
        rst = 1'b0;
        step();
        rst = 1'b1;
        i_read = 1'b1; i_addr = 32'h0000_5000;
        d_read = 1'b1; d_addr = 32'h0000_6000;
        for (int k = 0; k < 4; k++) begin
            sb.push_back(mk(rr_d[k], 1'b0, rr_d[k] ? 32'h0000_6000 : 32'h0000_5000, '0));
        end
        for (int k = 0; k < 4; k++) begin
            mem_txn($sformatf("arb%0d", k), 1, {32{k[7:0]}}, 1);
        end
        i_read = 1'b0;
        d_read = 1'b0;
        step();

        // reset in the middle of a D fill
        d_read = 1'b1;
        d_addr = 32'h0000_4000;
        step();
        check("midrst_granted", pmem_read, 1'b1);
        step();
        rst       = 1'b0;
        d_read    = 1'b0;
        pmem_resp = 1'b1;
        #1;
        check("midrst_strobes", {pmem_read, pmem_write}, 2'b00);
        check("midrst_no_resp", {i_resp, d_resp}, 2'b00);
        check("midrst_addr", pmem_addr, 32'h0);
        step();
        rst       = 1'b1;
        pmem_resp = 1'b0;
        #1;
        check("midrst_idle", {pmem_read, pmem_write}, 2'b00);
        step();
        check("midrst_idle2", {pmem_read, pmem_write}, 2'b00);

        check("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
